task_dispatcher: RTL and testbench
==================================

# task_dispatcher

Parametrised GPU task dispatcher, successor to the fixed 16-core scheduler. Walks a task program in shared program memory through a 1-cycle-latency read port. For each task it enforces core-busy and fence hazards, writes per-core r0 init values, then streams the task's instruction words to the selected cores over a valid/ready channel. It sits between program memory and the core array and replaces whole-memory array input with a narrow read port.

## Interface
Parameters:
- CORE_NUM, 16, number of cores (2..32)
- WORD_W, 16, program word width (≥ CORE_NUM, ≥ 8)
- ADDR_W, 10, program memory address width
- FRAME_WORDS, 16, words per instruction frame (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begin program at start_addr (honoured only in IDLE/DONE)
- start_addr  in  ADDR_W  first task header address
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  WORD_W  data for the address strobed in the previous cycle
- core_done  in  CORE_NUM  per-core task-complete pulse
- busy_mask  out  CORE_NUM  cores currently running a task
- r0_we  out  CORE_NUM  one-hot r0 write enable
- r0_data  out  WORD_W  r0 value
- instr_valid  out  1  instruction word valid
- instr_ready  in  1  accepting cores ready
- instr_data  out  WORD_W  instruction word
- instr_mask  out  CORE_NUM  target cores of the current stream
- done  out  1  program finished and all cores idle

## Operation
- Task layout at base B:
  - B+0: [7:6] fence, [5:0] if_num
  - B+1: core mask (low CORE_NUM bits)
  - B+2: r0 mask
  - B+3+i, i<CORE_NUM: r0 value for core i
  - then if_num*FRAME_WORDS instruction words.
- Next header is at B+3+CORE_NUM+if_num*FRAME_WORDS. Addresses wrap modulo 2^ADDR_W.
- Fence: bit0 = ACQ (tasks after this one wait until this task's cores all finish); bit1 = REL (this task waits until busy_mask==0); 3 = both.
- FSM states:
  - IDLE: start → HDR with ptr=start_addr.
  - HDR: read 3 header words. A core mask of 0 → DONE. Otherwise → WAIT.
  - WAIT: issue when (busy_mask & mask)==0, acq_pending==0, and (!fence[1] or busy_mask==0). On issue:
    - busy_mask |= mask
    - if fence[0], set acq_pending and acq_mask=mask
    - → R0.
  - R0: read CORE_NUM words. For word i with r0 mask bit i set, pulse r0_we[i] with r0_data=word; otherwise no write. Then → STREAM if if_num≠0, else → HDR at the next header.
  - STREAM: instr_mask=mask held. Words are presented in address order. A word transfers on instr_valid&instr_ready. After if_num*FRAME_WORDS transfers → HDR.
  - DONE: done=1 while busy_mask==0. start → HDR.
- core_done[i] clears busy_mask[i]. acq_pending clears when (busy_mask & acq_mask)==0. core_done on a non-busy bit is ignored.
- Same-cycle set and clear on one bit cannot occur, because issue requires the bit to be clear.
- STREAM uses a 2-entry skid buffer. Reads issue only when buffer space is guaranteed, so no word is lost or duplicated under any ready pattern.
- start outside IDLE/DONE is ignored. reset at any point aborts the program immediately.

## Timing
- Reset values: every output 0, state IDLE, busy_mask 0, acq_pending 0.
- start sampled at cycle t → HDR at t+1. HDR occupies 4 cycles: addresses B..B+2 at t+1..t+3, data lands t+2..t+4, WAIT at t+5.
- WAIT→R0 takes 1 cycle when no hazard. r0_we pulses occur in R0 cycles 2..CORE_NUM+1. R0 lasts CORE_NUM+1 cycles.
- First instr_valid is 2 cycles after STREAM entry. With instr_ready held high the stream sustains 1 word/cycle.
- instr_valid, once high, holds with stable instr_data until accepted.
- busy_mask updates the cycle after issue or after core_done. A done pulse at cycle c permits a blocked issue at c+1 (WAIT re-evaluated every cycle).
- done rises the cycle after entering DONE with busy_mask==0, or the cycle after busy_mask reaches 0.

## Test plan
- Single task (CORE_NUM=16, FRAME_WORDS=16), mask=0x0003, r0 mask=0x0002, if_num=1, then a mask=0 header → exactly one r0_we=0x0002 with the B+4 value; 16 instr words B+19..B+34 with instr_mask=0x0003; done after core_done=0x0003.
- Core conflict: task A mask 0x0001, task B mask 0x0001 → B stays in WAIT until core_done[0]; B's r0 phase starts the cycle after.
- Fences:
  - A with ACQ (mask 0x00F0), B with mask 0x0001 → B waits for all of 0x00F0 to finish.
  - C with REL waits for busy_mask==0 despite disjoint masks.
- Backpressure: instr_ready toggling in a 1-of-3 pattern over 32 words → the received sequence exactly equals memory order, with no gaps, repeats or losses.
- if_num=0 task followed by a next header at B+19: no instr_valid is produced and the next header is read from B+19. Also set start_addr=0x3FE to check address wrap.
- reset asserted mid-STREAM → all outputs 0 the next cycle; a new start replays the program from scratch.

Source files
------------

// File: rtl/task_dispatcher.sv
// task_dispatcher: walks a task program in program memory through a
// 1-cycle-latency read port, enforces core-busy and fence hazards, writes
// per-core r0 init values and streams instruction words to the target cores.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start/start_addr  begin a program at start_addr (only from IDLE or DONE)
//   mem_rd_en/mem_addr/mem_rdata  program memory read port (data next cycle)
//   core_done         per-core task-complete pulses
//   busy_mask         cores currently running a task
//   r0_we/r0_data     one-hot r0 write enable and value
//   instr_valid/instr_ready/instr_data/instr_mask  instruction stream
//   done              program finished and all cores idle
module task_dispatcher #(
  parameter int CORE_NUM    = 16,
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int FRAME_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic [CORE_NUM-1:0] core_done,
  output logic [CORE_NUM-1:0] busy_mask,
  output logic [CORE_NUM-1:0] r0_we,
  output logic [WORD_W-1:0]   r0_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [WORD_W-1:0]   instr_data,
  output logic [CORE_NUM-1:0] instr_mask,
  output logic                done
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_R0     = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int FW_SH = $clog2(FRAME_WORDS);
  localparam int CNT_W = 7 + FW_SH;  // holds 63*FRAME_WORDS and CORE_NUM
  localparam logic [ADDR_W-1:0] BODY_OFS = ADDR_W'(3 + CORE_NUM);

  logic [2:0]          state;
  logic [ADDR_W-1:0]   ptr;
  logic [CNT_W-1:0]    cnt, rd_cnt, total;
  logic [1:0]          fence;
  logic [5:0]          if_num;
  logic [CORE_NUM-1:0] mask, r0_mask, acq_mask, r0_sel;
  logic                acq_pending, acq_block, issue;
  logic [WORD_W-1:0]   fifo [2];
  logic                wp, rp, rd_q, push, pop, last_xfer;
  logic [1:0]          fcount;
  logic [2:0]          occ_next;
  logic                hdr_rd, r0_rd, stream_rd;
  logic [ADDR_W-1:0]   rd_addr;

  assign total = CNT_W'(if_num) << FW_SH;

  // An ACQ fence only blocks while one of its cores is still busy, so a
  // core_done at cycle c can release a waiting task at c+1.
  assign acq_block = acq_pending && |(busy_mask & acq_mask);
  assign issue     = (state == S_WAIT) && ~|(busy_mask & mask) && !acq_block &&
                     (!fence[1] || ~|busy_mask);

  assign instr_valid = (state == S_STREAM) && (fcount != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign push        = rd_q;
  assign last_xfer   = pop && (cnt == total - CNT_W'(1));

  // Occupancy after this cycle's push/pop; a read issued now lands next
  // cycle, so it is only safe when that occupancy leaves a free slot even
  // if nothing is popped next cycle.
  assign occ_next  = 3'(fcount) + 3'(rd_q) - 3'(pop);
  assign hdr_rd    = (state == S_HDR) && (cnt < CNT_W'(3));
  assign r0_rd     = (state == S_R0) && (cnt < CNT_W'(CORE_NUM));
  assign stream_rd = (state == S_STREAM) && (rd_cnt < total) && (occ_next <= 3'd1);

  always_comb begin
    rd_addr = '0;
    if (hdr_rd)         rd_addr = ptr + ADDR_W'(cnt);
    else if (r0_rd)     rd_addr = ptr + ADDR_W'(3) + ADDR_W'(cnt);
    else if (stream_rd) rd_addr = ptr + BODY_OFS + ADDR_W'(rd_cnt);
  end

  assign mem_rd_en = hdr_rd | r0_rd | stream_rd;
  assign mem_addr  = rd_addr;

  // R0 word i arrives in R0 cycle i+1 (cnt == i+1).
  always_comb begin
    r0_sel = '0;
    if (state == S_R0 && cnt != '0) r0_sel = CORE_NUM'(1) << (cnt - CNT_W'(1));
  end
  assign r0_we      = r0_sel & r0_mask;
  assign r0_data    = |r0_we ? mem_rdata : '0;
  assign instr_data = instr_valid ? fifo[rp] : '0;
  assign instr_mask = (state == S_STREAM) ? mask : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      rd_cnt      <= '0;
      fence       <= '0;
      if_num      <= '0;
      mask        <= '0;
      r0_mask     <= '0;
      acq_pending <= 1'b0;
      acq_mask    <= '0;
      busy_mask   <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      fcount      <= '0;
      rd_q        <= 1'b0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
      done        <= 1'b0;
    end else begin
      // Issue only targets idle cores, so set and clear never collide.
      busy_mask <= (busy_mask & ~core_done) | (issue ? mask : '0);
      if (issue && fence[0]) begin
        acq_pending <= 1'b1;
        acq_mask    <= mask;
      end else if (acq_pending && !acq_block) begin
        acq_pending <= 1'b0;
      end

      done <= (state == S_DONE) && (busy_mask == '0) && !start;

      rd_q <= stream_rd;
      if (push) begin
        fifo[wp] <= mem_rdata;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      fcount <= fcount + 2'(push) - 2'(pop);
      if (stream_rd) rd_cnt <= rd_cnt + CNT_W'(1);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_HDR;
            ptr   <= start_addr;
            cnt   <= '0;
          end
        end
        S_HDR: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(1)) {fence, if_num} <= mem_rdata[7:0];
          if (cnt == CNT_W'(2)) mask <= mem_rdata[CORE_NUM-1:0];
          if (cnt == CNT_W'(3)) begin
            r0_mask <= mem_rdata[CORE_NUM-1:0];
            state   <= (mask == '0) ? S_DONE : S_WAIT;
            cnt     <= '0;
          end
        end
        S_WAIT: begin
          if (issue) begin
            state <= S_R0;
            cnt   <= '0;
          end
        end
        S_R0: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CORE_NUM)) begin
            cnt <= '0;
            if (if_num != 6'd0) begin
              state  <= S_STREAM;
              rd_cnt <= '0;
            end else begin
              state <= S_HDR;
              ptr   <= ptr + BODY_OFS;
            end
          end
        end
        S_STREAM: begin
          if (pop) cnt <= cnt + CNT_W'(1);
          if (last_xfer) begin
            state <= S_HDR;
            cnt   <= '0;
            ptr   <= ptr + BODY_OFS + ADDR_W'(total);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_task_dispatcher.sv
// Self-checking bench for task_dispatcher (CORE_NUM=16, WORD_W=16,
// ADDR_W=10, FRAME_WORDS=16). Programs are built in a bench-side memory with
// random payloads; a task-walking model derives the expected r0 writes and
// instruction stream, and each test compares what the monitor captured.
module tb_task_dispatcher;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] core_done = '0;
  logic [15:0] busy_mask;
  logic [15:0] r0_we;
  logic [15:0] r0_data;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr_data;
  logic [15:0] instr_mask;
  logic        done;

  task_dispatcher #(.CORE_NUM(16), .WORD_W(16), .ADDR_W(10), .FRAME_WORDS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .core_done(core_done), .busy_mask(busy_mask), .r0_we(r0_we), .r0_data(r0_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_mask(instr_mask), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] obs_r0[$], obs_ins[$], exp_r0[$], exp_ins[$];
  int first_x, last_x, hold_viol, mask8_valid;
  logic saw_011;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (|r0_we) obs_r0.push_back({r0_we, r0_data});
      if (instr_valid && instr_ready) begin
        obs_ins.push_back({instr_data, instr_mask});
        if (obs_ins.size() == 1) first_x = cyc;
        last_x = cyc;
      end
      if (prev_stall && (!instr_valid || instr_data !== prev_data)) hold_viol++;
      if (instr_valid && instr_mask == 16'h0008) mask8_valid++;
      if (mem_rd_en && mem_addr == 10'h011) saw_011 = 1'b1;
      prev_stall = instr_valid && !instr_ready;
      prev_data  = instr_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- program building and reference model ----------------
  task automatic put_task(input logic [9:0] b, input logic [1:0] f, input logic [5:0] n,
                          input logic [15:0] m, input logic [15:0] rm, output logic [9:0] nxt);
    logic [9:0] a;
    mem[b] = {8'($urandom), f, n};
    a = b + 10'd1; mem[a] = m;
    a = b + 10'd2; mem[a] = rm;
    for (int i = 0; i < 16; i++) begin a = b + 10'(3 + i); mem[a] = 16'($urandom); end
    for (int j = 0; j < int'(n) * 16; j++) begin a = b + 10'(19 + j); mem[a] = 16'($urandom); end
    nxt = b + 10'(19 + int'(n) * 16);
  endtask

  task automatic put_end(input logic [9:0] b);
    logic [9:0] a;
    mem[b] = 16'($urandom);
    a = b + 10'd1; mem[a] = 16'h0;
  endtask

  // Walks the program by its layout rules: tasks in order, r0 writes for
  // every set r0-mask bit, then the task's instruction words in address order.
  task automatic build_expect(input logic [9:0] s);
    logic [9:0] p, a;
    logic [15:0] h, m, rm;
    int n;
    exp_r0.delete(); exp_ins.delete();
    p = s;
    for (int t = 0; t < 8; t++) begin
      a = p + 10'd1; m = mem[a];
      if (m == 16'h0) break;
      h = mem[p];
      a = p + 10'd2; rm = mem[a];
      for (int i = 0; i < 16; i++)
        if (rm[i]) begin a = p + 10'(3 + i); exp_r0.push_back({16'(1 << i), mem[a]}); end
      n = int'(h[5:0]) * 16;
      for (int j = 0; j < n; j++) begin a = p + 10'(19 + j); exp_ins.push_back({mem[a], m}); end
      p = p + 10'(19 + n);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; core_done = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    obs_r0.delete(); obs_ins.delete();
    hold_viol = 0; mask8_valid = 0; saw_011 = 1'b0;
  endtask

  task automatic kick(input logic [9:0] a);
    @(posedge clk); #1;
    start_addr = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] m);
    @(posedge clk); #1 core_done = m;
    @(posedge clk); #1 core_done = '0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  // ------------------------------- tests --------------------------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({mem_rd_en, mem_addr, r0_we, r0_data, instr_valid} !== '0) begin
      n_fail++; $display("FAIL reset_mem_r0 got %h want 0", {mem_rd_en, mem_addr, r0_we, r0_data, instr_valid});
    end
    n_checks++;
    if ({busy_mask, instr_data, instr_mask, done} !== '0) begin
      n_fail++; $display("FAIL reset_busy_instr got %h want 0", {busy_mask, instr_data, instr_mask, done});
    end
  endtask

  task automatic test_single();
    logic [9:0] nx;
    logic ok;
    apply_reset();
    put_task(10'h010, 2'd0, 6'd1, 16'h0003, 16'h0002, nx);
    put_end(nx);
    build_expect(10'h010);
    kick(10'h010);
    @(negedge clk);
    n_checks++;
    if ({mem_rd_en, mem_addr} !== {1'b1, 10'h010}) begin
      n_fail++; $display("FAIL single_first_read got %b/%h want 1/010", mem_rd_en, mem_addr);
    end
    for (int k = 0; k < 200 && obs_ins.size() < 16; k++) @(negedge clk);
    n_checks++;
    if (obs_ins.size() != 16) begin
      n_fail++; $display("FAIL single_instr_count got %0d want 16", obs_ins.size());
    end
    n_checks++;
    if (obs_r0.size() != 1 || obs_r0[0] !== {16'h0002, mem[10'h014]}) begin
      n_fail++; $display("FAIL single_r0 got n=%0d %h want 1 %h", obs_r0.size(),
                         (obs_r0.size() > 0) ? obs_r0[0] : 32'h0, {16'h0002, mem[10'h014]});
    end
    for (int i = 0; i < obs_ins.size() && i < exp_ins.size(); i++) begin
      n_checks++;
      if (obs_ins[i] !== exp_ins[i]) begin
        n_fail++; $display("FAIL single_word[%0d] got %h want %h", i, obs_ins[i], exp_ins[i]);
      end
    end
    n_checks++;
    if (last_x - first_x != 15) begin
      n_fail++; $display("FAIL single_throughput got span %0d want 15", last_x - first_x);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if ({done, busy_mask} !== {1'b0, 16'h0003}) begin
      n_fail++; $display("FAIL single_busy got done=%b busy=%h want 0/0003", done, busy_mask);
    end
    pulse_done(16'h0003);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL single_done got 0 want 1"); end
  endtask

  task automatic test_conflict();
    logic [9:0] nx;
    logic ok;
    apply_reset();
    put_task(10'h100, 2'd0, 6'd0, 16'h0001, 16'h0001, nx);
    put_task(nx, 2'd0, 6'd0, 16'h0001, 16'h0001, nx);
    put_end(nx);
    build_expect(10'h100);
    kick(10'h100);
    for (int k = 0; k < 100 && obs_r0.size() < 1; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    n_checks++;
    if (obs_r0.size() != 1 || busy_mask !== 16'h0001) begin
      n_fail++; $display("FAIL conflict_blocked got n=%0d busy=%h want 1/0001", obs_r0.size(), busy_mask);
    end
    @(posedge clk); #1 core_done = 16'h0001;
    @(posedge clk); #1 core_done = '0;
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL conflict_clear got %h want 0000", busy_mask);
    end
    @(negedge clk);
    n_checks++;
    if (busy_mask !== 16'h0001) begin
      n_fail++; $display("FAIL conflict_reissue got %h want 0001", busy_mask);
    end
    @(negedge clk);
    n_checks++;
    if ({r0_we, r0_data} !== {16'h0001, mem[10'h116]}) begin
      n_fail++; $display("FAIL conflict_r0_timing got %h want %h", {r0_we, r0_data}, {16'h0001, mem[10'h116]});
    end
    pulse_done(16'h0001);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1 || obs_r0.size() != 2 || obs_r0[1] !== exp_r0[1]) begin
      n_fail++; $display("FAIL conflict_end got done=%b n=%0d want 1/2", ok, obs_r0.size());
    end
  endtask

  task automatic test_fence();
    logic [9:0] nx;
    logic ok;
    apply_reset();
    put_task(10'h200, 2'd1, 6'd0, 16'h00F0, 16'h00F0, nx);
    put_task(nx, 2'd0, 6'd0, 16'h0001, 16'h0001, nx);
    put_task(nx, 2'd2, 6'd0, 16'h0002, 16'h0002, nx);
    put_end(nx);
    build_expect(10'h200);
    kick(10'h200);
    for (int k = 0; k < 100 && obs_r0.size() < 4; k++) @(negedge clk);
    pulse_done(16'h0030);
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_r0.size() != 4 || busy_mask !== 16'h00C0) begin
      n_fail++; $display("FAIL fence_acq_hold got n=%0d busy=%h want 4/00C0", obs_r0.size(), busy_mask);
    end
    pulse_done(16'h00C0);
    for (int k = 0; k < 40 && obs_r0.size() < 5; k++) @(negedge clk);
    repeat (30) @(negedge clk);
    n_checks++;
    if (obs_r0.size() != 5 || busy_mask !== 16'h0001) begin
      n_fail++; $display("FAIL fence_rel_hold got n=%0d busy=%h want 5/0001", obs_r0.size(), busy_mask);
    end
    pulse_done(16'h0001);
    for (int k = 0; k < 40 && obs_r0.size() < 6; k++) @(negedge clk);
    n_checks++;
    if (obs_r0.size() != 6) begin
      n_fail++; $display("FAIL fence_rel_issue got n=%0d want 6", obs_r0.size());
    end
    for (int i = 0; i < obs_r0.size() && i < exp_r0.size(); i++) begin
      n_checks++;
      if (obs_r0[i] !== exp_r0[i]) begin
        n_fail++; $display("FAIL fence_r0[%0d] got %h want %h", i, obs_r0[i], exp_r0[i]);
      end
    end
    pulse_done(16'h0002);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL fence_done got 0 want 1"); end
  endtask

  task automatic test_backpressure();
    logic [9:0] nx;
    logic ok;
    apply_reset();
    put_task(10'h080, 2'd0, 6'd2, 16'h0005, 16'($urandom), nx);
    put_end(nx);
    build_expect(10'h080);
    kick(10'h080);
    for (int k = 0; k < 600 && obs_ins.size() < 32; k++) begin
      @(posedge clk); #1 instr_ready = (k % 3 == 0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_ins.size() != 32 || hold_viol != 0) begin
      n_fail++; $display("FAIL bp_count got n=%0d holdviol=%0d want 32/0", obs_ins.size(), hold_viol);
    end
    for (int i = 0; i < obs_ins.size() && i < exp_ins.size(); i++) begin
      n_checks++;
      if (obs_ins[i] !== exp_ins[i]) begin
        n_fail++; $display("FAIL bp_word[%0d] got %h want %h", i, obs_ins[i], exp_ins[i]);
      end
    end
    n_checks++;
    if (obs_r0 != exp_r0) begin
      n_fail++; $display("FAIL bp_r0 got n=%0d want n=%0d", obs_r0.size(), exp_r0.size());
    end
    pulse_done(16'h0005);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_done got 0 want 1"); end
  endtask

  task automatic test_ifnum0_wrap();
    logic [9:0] nx;
    logic ok;
    apply_reset();
    put_task(10'h3FE, 2'd0, 6'd0, 16'h0008, 16'h0008, nx);
    put_task(nx, 2'd0, 6'd1, 16'h0010, 16'h0010, nx);
    put_end(nx);
    build_expect(10'h3FE);
    kick(10'h3FE);
    for (int k = 0; k < 300 && obs_ins.size() < 16; k++) @(negedge clk);
    n_checks++;
    if (saw_011 !== 1'b1 || mask8_valid != 0) begin
      n_fail++; $display("FAIL wrap_hdr got saw011=%b validA=%0d want 1/0", saw_011, mask8_valid);
    end
    n_checks++;
    if (obs_r0.size() != 2 || obs_r0[0] !== {16'h0008, mem[10'h004]}) begin
      n_fail++; $display("FAIL wrap_r0 got n=%0d want 2 first %h", obs_r0.size(), {16'h0008, mem[10'h004]});
    end
    n_checks++;
    if (obs_ins != exp_ins) begin
      n_fail++; $display("FAIL wrap_instr got n=%0d want n=%0d", obs_ins.size(), exp_ins.size());
    end
    pulse_done(16'h0018);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_done got 0 want 1"); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] nx;
    logic ok;
    apply_reset();
    put_task(10'h300, 2'd0, 6'd2, 16'h0C00, 16'($urandom), nx);
    put_end(nx);
    build_expect(10'h300);
    instr_ready = 1'b0;
    kick(10'h300);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_stream got valid=0 want 1"); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_rd_en, mem_addr, busy_mask, r0_we, r0_data, instr_valid, instr_data, instr_mask, done} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs got %h want 0",
                         {mem_rd_en, mem_addr, busy_mask, r0_we, r0_data, instr_valid, instr_data, instr_mask, done});
    end
    @(posedge clk); #1 reset = 1'b0;
    obs_r0.delete(); obs_ins.delete();
    instr_ready = 1'b1;
    kick(10'h300);
    for (int k = 0; k < 300 && obs_ins.size() < 32; k++) @(negedge clk);
    n_checks++;
    if (obs_ins != exp_ins || obs_r0 != exp_r0) begin
      n_fail++; $display("FAIL rmid_replay got ins=%0d r0=%0d want ins=%0d r0=%0d",
                         obs_ins.size(), obs_r0.size(), exp_ins.size(), exp_r0.size());
    end
    pulse_done(16'h0C00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_done got 0 want 1"); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    test_reset();
    test_single();
    test_conflict();
    test_fence();
    test_backpressure();
    test_ifnum0_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
